// File: rtl/shifter_operand.sv
// shifter_operand: iterative ARM operand-2 barrel shifter (LSL/LSR/ASR/ROR/RRX/ROT_IMM), one bit per clock; define SHIFTER_SINGLE_CYCLE_EN for single-cycle results
// Ports: clk, reset (async, active-high); start/shift_type/operand/shamt/carry_in request;
//        busy (SHIFT state), done (one-cycle result pulse), shifter_out (ALU B), shifter_carry (ALU carry-in)
module shifter_operand #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       shift_type,
  input  logic [WIDTH-1:0] operand,
  input  logic [4:0]       shamt,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] shifter_out,
  output logic             shifter_carry
);
  localparam logic [2:0] LSL = 3'b000, LSR = 3'b001, ASR = 3'b010, RRX = 3'b100, ROT = 3'b101;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] work, load_val, step_val;
  logic [CNT_W-1:0] cnt, load_n;
  logic [2:0] typ;
  logic carry_reg, step_c, accept;
  // One shift step, returned as {carry_out, next_value}; ROR and ROT_IMM share the rotate step.
  function automatic logic [WIDTH:0] step(input logic [2:0] t, input logic [WIDTH-1:0] r, input logic c);
    return t == LSL ? {r[WIDTH-1], r[WIDTH-2:0], 1'b0} :
           t == LSR ? {r[0], 1'b0, r[WIDTH-1:1]} :
           t == ASR ? {r[0], r[WIDTH-1], r[WIDTH-1:1]} :
           t == RRX ? {r[0], c, r[WIDTH-1:1]} :
                      {r[0], r[0], r[WIDTH-1:1]};
  endfunction
  assign accept = start && state != SHIFT;
  assign load_val = shift_type == ROT ? {{(WIDTH-8){1'b0}}, operand[7:0]} : operand;
  // LSR/ASR encode #WIDTH as shamt=0; 110/111 pass the operand straight through.
  assign load_n = (shift_type == LSR || shift_type == ASR) ? (shamt == 5'd0 ? CNT_W'(WIDTH) : CNT_W'(shamt)) :
                  shift_type == RRX ? CNT_W'(1) :
                  shift_type == ROT ? CNT_W'({shamt[3:0], 1'b0}) :
                  shift_type[2] ? '0 : CNT_W'(shamt);
  assign {step_c, step_val} = step(typ, work, carry_reg);
`ifdef SHIFTER_SINGLE_CYCLE_EN
  logic [WIDTH-1:0] full_val;
  logic full_c;
  // Unrolled chain of the same step used iteratively, so both modes agree bit for bit.
  always_comb begin
    {full_c, full_val} = {carry_in, load_val};
    for (int i = 0; i < WIDTH; i++)
      if (CNT_W'(i) < load_n) {full_c, full_val} = step(shift_type, full_val, full_c);
  end
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      work <= '0;
      cnt <= '0;
      typ <= '0;
      carry_reg <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      shifter_out <= '0;
      shifter_carry <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        work <= load_val;
        typ <= shift_type;
        carry_reg <= carry_in;
        cnt <= load_n;
`ifdef SHIFTER_SINGLE_CYCLE_EN
        state <= DONE;
        busy <= 1'b0;
        done <= 1'b1;
        shifter_out <= full_val;
        shifter_carry <= full_c;
`else
        if (load_n == '0) begin
          state <= DONE;
          busy <= 1'b0;
          done <= 1'b1;
          shifter_out <= load_val;
          shifter_carry <= carry_in;
        end else begin
          state <= SHIFT;
          busy <= 1'b1;
        end
`endif
      end else if (state == SHIFT) begin
        work <= step_val;
        carry_reg <= step_c;
        cnt <= cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state <= DONE;
          busy <= 1'b0;
          done <= 1'b1;
          shifter_out <= step_val;
          shifter_carry <= step_c;
        end
      end else begin
        state <= IDLE;
      end
    end
endmodule

// File: doc/shifter_operand.md
Name: shifter_operand

Overview:
- Iterative barrel-shifter stage directly upstream of the ALU.
- Produces the second operand (B) and the shifter carry-out, which drives the ALU carry input for logical ops.
- Supports the ARM data-processing shift forms: LSL, LSR, ASR, ROR, RRX, and rotated 8-bit immediate.
- Shifts one bit per clock under a start/busy/done handshake with the control unit.

Parameters:
WIDTH, 32, operand/result width
CNT_W, 6, width of internal shift counter (must hold 32)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  one clock; reset is asynchronous and active-high
start  input  1  request; sampled on rising clk when not busy
shift_type  input  3  000 LSL, 001 LSR, 010 ASR, 011 ROR, 100 RRX, 101 ROT_IMM, 110/111 pass-through
operand  input  WIDTH  value to shift (ROT_IMM uses operand[7:0] only)
shamt  input  5  shift amount (ROT_IMM: shamt[3:0] = rotate field)
carry_in  input  1  current C flag
busy  output  1  high while in SHIFT state
done  output  1  one-cycle pulse, result valid
shifter_out  output  WIDTH  shifted operand to ALU B
shifter_carry  output  1  shifter carry-out to ALU carry

Behaviour:
- Reset (async): state IDLE; shifter_out=0, shifter_carry=0, busy=0, done=0. Reset mid-operation aborts, with no done pulse.
- FSM states: IDLE, SHIFT, DONE.
- Accepting a request:
  - start is accepted in IDLE or DONE, so back-to-back requests are allowed; it is ignored in SHIFT.
  - On acceptance, latch working reg, carry_reg=carry_in, and count N.
- Count N and load values per shift_type:
  - LSL: N=shamt (0 = no shift).
  - LSR/ASR: N=shamt, except shamt=0 means N=32.
  - ROR: N=shamt.
  - RRX: N=1.
  - ROT_IMM: reg={24'b0, operand[7:0]}, N=2*shamt[3:0].
  - 110/111: N=0.
- Transition after acceptance: N=0 goes to DONE, otherwise SHIFT.
- SHIFT, one step per clk, count decrements; the step with count==1 moves to DONE.
  - LSL: carry<=reg[31], reg<=reg<<1.
  - LSR: carry<=reg[0], reg<=reg>>1.
  - ASR: carry<=reg[0], reg<={reg[31],reg[31:1]}.
  - ROR/ROT_IMM: carry<=reg[0], reg<={reg[0],reg[31:1]}.
  - RRX: carry<=reg[0], reg<={carry_reg,reg[31:1]}.
- N=0 keeps shifter_carry=carry_in.
- Latency: with start sampled at edge 0, done is high during the cycle following edge N (N=0: the cycle after edge 0).
- DONE lasts exactly one cycle:
  - done=1 and shifter_out/shifter_carry are valid.
  - Next state is IDLE, or a new operation if start is high.
- shifter_out/shifter_carry are updated only on the transition into DONE; they hold in IDLE until the next completion. Intermediate values are never visible.
- Boundary results:
  - LSR #32: result 0, carry=operand[31].
  - ASR #32: all bits = operand[31], carry=operand[31].
  - ROT_IMM with rot=0: carry=carry_in.

Optional Feature:
SHIFTER_SINGLE_CYCLE_EN
- Defined: the full result and carry are computed combinationally at acceptance. Every request goes IDLE→DONE, with done in the cycle after edge 0 regardless of N; busy never asserts. Result values are identical to the iterative mode.
- Undefined: iterative one-bit-per-cycle mode as specified above.

Test Plan:
1. LSL, operand=0x8000_0001, shamt=1, carry_in=0 -> shifter_out=0x0000_0002, shifter_carry=1, done after edge 1, busy high for 1 cycle.
2. LSR, operand=0x8000_0000, shamt=0 (=#32) -> shifter_out=0x0000_0000, carry=1, done after edge 32.
3. ASR, operand=0xF000_00F8, shamt=4 -> shifter_out=0xFF00_000F, carry=1. RRX, operand=0x0000_0003, carry_in=1 -> 0x8000_0001, carry=1.
4. ROT_IMM, operand[7:0]=0xFF, shamt=4 -> 0xFF00_0000, carry=1, done after edge 8. ROT_IMM, imm=0x81, shamt=0, carry_in=0 -> 0x0000_0081, carry=0, done after edge 0.
5. ROR, shamt=20; second start pulsed during busy -> ignored, first result unaffected. New start in the DONE cycle -> accepted back-to-back.
6. reset asserted at cycle 5 of ROR #20 -> busy=0, done=0, shifter_out=0, shifter_carry=0 immediately; no done pulse. Next request after release completes normally.
